// File: rtl/vga_frame_sequencer.sv
// Column/row timing generator for the VGA path: raw syncs, active flag, frame pulses,
// frame-boundary start/stop and a shadowed configuration word applied between frames.
module vga_frame_sequencer #(
    parameter int TOTAL_COLS  = 800,
    parameter int TOTAL_ROWS  = 525,
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int CFG_WIDTH   = 3
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_L,
    input  logic                 i_Start,
    input  logic                 i_Stop,
    input  logic                 i_Cfg_Valid,
    input  logic [CFG_WIDTH-1:0] i_Cfg_Data,
    output logic                 o_Cfg_Ready,
    output logic [CFG_WIDTH-1:0] o_Cfg,
    output logic                 o_HSync,
    output logic                 o_VSync,
    output logic [9:0]           o_Col_Count,
    output logic [9:0]           o_Row_Count,
    output logic                 o_Active,
    output logic                 o_Frame_Start,
    output logic [7:0]           o_Frame_Count,
    output logic                 o_Busy
);

    localparam logic [9:0] LAST_COL   = 10'(TOTAL_COLS - 1);
    localparam logic [9:0] LAST_ROW   = 10'(TOTAL_ROWS - 1);
    localparam logic [9:0] ACT_COLS   = 10'(ACTIVE_COLS);
    localparam logic [9:0] ACT_ROWS   = 10'(ACTIVE_ROWS);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_STOP_PEND = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [9:0]           col_r;
    logic [9:0]           row_r;
    logic [9:0]           col_nxt_s;
    logic [9:0]           row_nxt_s;
    logic [CFG_WIDTH-1:0] cfg_r;
    logic [CFG_WIDTH-1:0] shadow_r;
    logic                 shadow_full_r;
    logic [7:0]           frame_cnt_r;
    logic                 scanning_s;
    logic                 last_pix_s;
    logic                 xfer_s;

    assign scanning_s = (state_r != ST_IDLE);
    assign last_pix_s = scanning_s && (col_r == LAST_COL) && (row_r == LAST_ROW);
    assign xfer_s     = i_Cfg_Valid && !shadow_full_r;

    // Next-state selection; a start request always overrides a pending stop
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_Start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (i_Stop && !i_Start) begin
                    state_nxt_s = ST_STOP_PEND;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_STOP_PEND: begin
                if (i_Start) begin
                    state_nxt_s = ST_RUN;
                end else if (last_pix_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_STOP_PEND;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Raster counter advance; the final-pixel wrap lands on 0,0 which doubles as the idle value
    always_comb begin
        col_nxt_s = col_r;
        row_nxt_s = row_r;
        if (scanning_s) begin
            if (col_r == LAST_COL) begin
                col_nxt_s = 10'd0;
                if (row_r == LAST_ROW) begin
                    row_nxt_s = 10'd0;
                end else begin
                    row_nxt_s = row_r + 10'd1;
                end
            end else begin
                col_nxt_s = col_r + 10'd1;
                row_nxt_s = row_r;
            end
        end else begin
            col_nxt_s = 10'd0;
            row_nxt_s = 10'd0;
        end
    end

    // State and raster counter registers
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_r <= ST_IDLE;
            col_r   <= 10'd0;
            row_r   <= 10'd0;
        end else begin
            state_r <= state_nxt_s;
            col_r   <= col_nxt_s;
            row_r   <= row_nxt_s;
        end
    end

    // Config path: direct load when idle, otherwise staged in the shadow until the last pixel.
    // A word caught on the stopping frame's last pixel is drained from the shadow once idle.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cfg_r         <= {CFG_WIDTH{1'b0}};
            shadow_r      <= {CFG_WIDTH{1'b0}};
            shadow_full_r <= 1'b0;
        end else if (!scanning_s) begin
            if (shadow_full_r) begin
                cfg_r         <= shadow_r;
                shadow_full_r <= 1'b0;
            end else if (xfer_s) begin
                cfg_r <= i_Cfg_Data;
            end
        end else begin
            if (last_pix_s && shadow_full_r) begin
                cfg_r         <= shadow_r;
                shadow_full_r <= 1'b0;
            end else if (xfer_s) begin
                shadow_r      <= i_Cfg_Data;
                shadow_full_r <= 1'b1;
            end
        end
    end

    // Completed-frame counter, natural 8-bit wrap
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            frame_cnt_r <= 8'd0;
        end else if (last_pix_s) begin
            frame_cnt_r <= frame_cnt_r + 8'd1;
        end
    end

    assign o_Cfg_Ready   = !shadow_full_r;
    assign o_Cfg         = cfg_r;
    assign o_Col_Count   = col_r;
    assign o_Row_Count   = row_r;
    assign o_Frame_Count = frame_cnt_r;
    assign o_Busy        = scanning_s;
    assign o_HSync       = scanning_s ? (col_r < ACT_COLS) : 1'b1;
    assign o_VSync       = scanning_s ? (row_r < ACT_ROWS) : 1'b1;
    assign o_Active      = scanning_s && (col_r < ACT_COLS) && (row_r < ACT_ROWS);
    assign o_Frame_Start = scanning_s && (col_r == 10'd0) && (row_r == 10'd0);

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Self-checking bench for vga_frame_sequencer on a shrunken raster, with a
// pixel-index reference model driving randomized cycle-by-cycle comparison.
module tb_vga_frame_sequencer;

    localparam int TC = 20;
    localparam int TR = 12;
    localparam int AC = 16;
    localparam int AR = 9;
    localparam int N  = TC * TR;

    logic       clk = 1'b0;
    logic       rst_n, start, stop, cv;
    logic [2:0] cd;
    logic       o_Cfg_Ready, o_HSync, o_VSync, o_Active, o_Frame_Start, o_Busy;
    logic [2:0] o_Cfg;
    logic [9:0] o_Col_Count, o_Row_Count;
    logic [7:0] o_Frame_Count;

    int errors = 0;
    int checks = 0;

    // reference model: scanning flag, stop-pending flag, linear pixel index
    bit         m_scan, m_stop, m_full;
    int         m_pix;
    logic [2:0] m_cfg, m_sh;
    logic [7:0] m_fc;

    localparam logic [36:0] RST_VEC = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 10'd0, 10'd0, 8'd0};

    wire [36:0] dut_vec = {o_Busy, o_HSync, o_VSync, o_Active, o_Frame_Start, o_Cfg_Ready,
                           o_Cfg, o_Col_Count, o_Row_Count, o_Frame_Count};

    vga_frame_sequencer #(
        .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR), .CFG_WIDTH(3)
    ) dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Start(start), .i_Stop(stop),
        .i_Cfg_Valid(cv), .i_Cfg_Data(cd), .o_Cfg_Ready(o_Cfg_Ready), .o_Cfg(o_Cfg),
        .o_HSync(o_HSync), .o_VSync(o_VSync), .o_Col_Count(o_Col_Count),
        .o_Row_Count(o_Row_Count), .o_Active(o_Active), .o_Frame_Start(o_Frame_Start),
        .o_Frame_Count(o_Frame_Count), .o_Busy(o_Busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_scan = 1'b0; m_stop = 1'b0; m_full = 1'b0; m_pix = 0;
        m_cfg = 3'd0; m_sh = 3'd0; m_fc = 8'd0;
    endtask

    task automatic model_step();
        bit last, xfer;
        last = m_scan && (m_pix == N - 1);
        xfer = cv && !m_full;
        if (!m_scan) begin
            if (m_full) begin m_cfg = m_sh; m_full = 1'b0; end
            else if (xfer) m_cfg = cd;
        end else begin
            if (last && m_full) begin m_cfg = m_sh; m_full = 1'b0; end
            else if (xfer) begin m_sh = cd; m_full = 1'b1; end
        end
        if (last) m_fc = m_fc + 8'd1;
        if (!m_scan) begin
            if (start) begin m_scan = 1'b1; m_stop = 1'b0; m_pix = 0; end
        end else begin
            m_pix = (m_pix + 1) % N;
            if (m_stop) begin
                if (start) m_stop = 1'b0;
                else if (last) m_scan = 1'b0;
            end else if (stop && !start) begin
                m_stop = 1'b1;
            end
        end
    endtask

    function automatic logic [36:0] exp_vec();
        logic [9:0] c, r;
        c = m_scan ? 10'(m_pix % TC) : 10'd0;
        r = m_scan ? 10'(m_pix / TC) : 10'd0;
        return {m_scan, (m_scan ? (c < AC) : 1'b1), (m_scan ? (r < AR) : 1'b1),
                m_scan && (c < AC) && (r < AR), m_scan && (m_pix == 0), !m_full,
                m_cfg, c, r, m_fc};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dut_vec !== RST_VEC) $display("FAIL reset_hold: got %h expected %h", dut_vec, RST_VEC);
        if (dut_vec !== RST_VEC) errors++;
        @(negedge clk) rst_n = 1'b1;
        tick();
        checks++;
        if (dut_vec !== RST_VEC) begin
            errors++;
            $display("FAIL reset_idle: got %h expected %h", dut_vec, RST_VEC);
        end
    endtask

    task automatic test_first_line();
        start = 1'b1; tick(); start = 1'b0;
        checks++;
        if (o_Busy !== 1'b1 || o_Frame_Start !== 1'b1 || o_Col_Count !== 10'd0 || o_Row_Count !== 10'd0) begin
            errors++;
            $display("FAIL start_first: busy=%b fs=%b col=%0d row=%0d expected 1 1 0 0",
                     o_Busy, o_Frame_Start, o_Col_Count, o_Row_Count);
        end
        for (int c = 1; c < TC; c++) begin
            tick();
            checks++;
            if (o_Col_Count !== 10'(c) || o_HSync !== 1'(c < AC) || o_Frame_Start !== 1'b0) begin
                errors++;
                $display("FAIL line_hsync: col=%0d hs=%b fs=%b expected col=%0d hs=%b fs=0",
                         o_Col_Count, o_HSync, o_Frame_Start, c, (c < AC));
            end
        end
        tick();
        checks++;
        if (o_Row_Count !== 10'd1 || o_Col_Count !== 10'd0) begin
            errors++;
            $display("FAIL row_advance: row=%0d col=%0d expected 1 0", o_Row_Count, o_Col_Count);
        end
    endtask

    task automatic test_full_frame();
        for (int p = TC + 1; p <= N; p++) begin
            tick();
            if (p < N) begin
                checks++;
                if (o_VSync !== 1'((p / TC) < AR) || o_Frame_Start !== 1'b0 || o_Frame_Count !== 8'd0) begin
                    errors++;
                    $display("FAIL frame_vsync: pix=%0d vs=%b fs=%b fc=%0d expected vs=%b fs=0 fc=0",
                             p, o_VSync, o_Frame_Start, o_Frame_Count, ((p / TC) < AR));
                end
            end
        end
        checks++;
        if (o_Frame_Start !== 1'b1 || o_Frame_Count !== 8'd1 || o_Col_Count !== 10'd0 || o_Row_Count !== 10'd0) begin
            errors++;
            $display("FAIL second_frame: fs=%b fc=%0d col=%0d row=%0d expected 1 1 0 0",
                     o_Frame_Start, o_Frame_Count, o_Col_Count, o_Row_Count);
        end
    endtask

    task automatic test_stop();
        int n;
        bit ok;
        repeat (5 * TC) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        n = 0;
        while (o_Busy === 1'b1 && n < N + 2) begin tick(); n++; end
        checks++;
        if (n != N - 5 * TC - 1 || o_Busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_latency: got %0d cycles busy=%b expected %0d busy=0", n, o_Busy, N - 5 * TC - 1);
        end
        checks++;
        if (dut_vec !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 10'd0, 10'd0, 8'd2}) begin
            errors++;
            $display("FAIL stop_idle: got %h expected idle with frame count 2", dut_vec);
        end
        start = 1'b1; tick(); start = 1'b0;
        repeat (5 * TC) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        repeat (3 * TC - 1) tick();
        start = 1'b1; tick(); start = 1'b0;
        n = 0; ok = 1'b1;
        while (o_Frame_Start !== 1'b1 && n < N) begin
            tick(); n++;
            if (o_Busy !== 1'b1) ok = 1'b0;
        end
        checks++;
        if (!ok || n != N - 8 * TC - 1 || o_Frame_Count !== 8'd3) begin
            errors++;
            $display("FAIL stop_cancel: stayed_busy=%b cycles=%0d fc=%0d expected 1 %0d 3",
                     ok, n, o_Frame_Count, N - 8 * TC - 1);
        end
    endtask

    task automatic test_back_to_back();
        int n, bad;
        repeat (3 * TC) tick();
        cv = 1'b1; cd = 3'b101;
        checks++;
        if (o_Cfg_Ready !== 1'b1) begin
            errors++;
            $display("FAIL cfg_ready_before: got %b expected 1", o_Cfg_Ready);
        end
        tick();
        cd = 3'b010;
        n = 0; bad = 0;
        while (n < N) begin
            tick(); n++;
            if (o_Frame_Start === 1'b1) break;
            if (o_Cfg !== 3'd0 || o_Cfg_Ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || n != N - 3 * TC - 1 || o_Cfg !== 3'b101 || o_Cfg_Ready !== 1'b1) begin
            errors++;
            $display("FAIL cfg_apply: early_changes=%0d cycles=%0d cfg=%b ready=%b expected 0 %0d 101 1",
                     bad, n, o_Cfg, o_Cfg_Ready, N - 3 * TC - 1);
        end
        tick();
        cv = 1'b0;
        checks++;
        if (o_Cfg_Ready !== 1'b0 || o_Cfg !== 3'b101) begin
            errors++;
            $display("FAIL cfg_stall_accept: ready=%b cfg=%b expected 0 101", o_Cfg_Ready, o_Cfg);
        end
        n = 0; bad = 0;
        while (n < N) begin
            tick(); n++;
            if (o_Frame_Start === 1'b1) break;
            if (o_Cfg !== 3'b101) bad++;
        end
        checks++;
        if (bad != 0 || o_Cfg !== 3'b010 || o_Cfg_Ready !== 1'b1) begin
            errors++;
            $display("FAIL cfg_second_apply: early_changes=%0d cfg=%b ready=%b expected 0 010 1",
                     bad, o_Cfg, o_Cfg_Ready);
        end
        stop = 1'b1; tick(); stop = 1'b0;
        n = 0;
        while (o_Busy === 1'b1 && n < N + 2) begin tick(); n++; end
        cv = 1'b1; cd = 3'b111; tick(); cv = 1'b0;
        checks++;
        if (o_Busy !== 1'b0 || o_Cfg !== 3'b111 || o_Cfg_Ready !== 1'b1) begin
            errors++;
            $display("FAIL cfg_idle_direct: busy=%b cfg=%b ready=%b expected 0 111 1", o_Busy, o_Cfg, o_Cfg_Ready);
        end
    endtask

    task automatic test_async_reset();
        int bad;
        start = 1'b1; tick(); start = 1'b0;
        repeat (2 * TC + 6) tick();
        cv = 1'b1; cd = 3'b110; tick(); cv = 1'b0;
        checks++;
        if (o_Cfg_Ready !== 1'b0 || o_Cfg !== 3'b111) begin
            errors++;
            $display("FAIL shadow_full: ready=%b cfg=%b expected 0 111", o_Cfg_Ready, o_Cfg);
        end
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== RST_VEC) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", dut_vec, RST_VEC);
        end
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        bad = 0;
        repeat (N + TC) begin
            tick();
            if (o_Cfg !== 3'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL shadow_discard: cfg nonzero on %0d cycles expected 0", bad);
        end
    endtask

    task automatic test_random();
        repeat (3000) begin
            start = ($urandom_range(0, 199) == 0);
            stop  = ($urandom_range(0, 99) == 0);
            cv    = ($urandom_range(0, 3) == 0);
            cd    = 3'($urandom_range(0, 7));
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random_vs_model: got %h expected %h", dut_vec, exp_vec());
            end
        end
        start = 1'b0; stop = 1'b0; cv = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; cv = 1'b0; cd = 3'd0;
        test_reset();
        test_first_line();
        test_full_frame();
        test_stop();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_frame_sequencer.md
Name: vga_frame_sequencer

Overview:
Top-level timing controller for the 640x480 VGA path.
- Runs the column/row counters and generates the raw HSync/VSync and active-video flag that feed the porch stage.
- Starts and stops scanning only on frame boundaries.
- Accepts pattern/mode configuration through a valid/ready handshake and applies it glitch-free at the next frame boundary.

Parameters:
TOTAL_COLS, 800, total pixels per line including blanking
TOTAL_ROWS, 525, total lines per frame including blanking
ACTIVE_COLS, 640, visible pixels per line
ACTIVE_ROWS, 480, visible lines per frame
CFG_WIDTH, 3, width of the pattern/mode configuration word

Ports:
i_Clk  in  1  pixel clock, 25 MHz
i_Rst_L  in  1  asynchronous active-low reset
i_Start  in  1  request to begin scanning (level or pulse)
i_Stop  in  1  request to stop at end of current frame
i_Cfg_Valid  in  1  configuration word valid
i_Cfg_Data  in  CFG_WIDTH  configuration word
o_Cfg_Ready  out  1  shadow register can accept a word
o_Cfg  out  CFG_WIDTH  configuration currently in force
o_HSync  out  1  raw HSync: 1 while col < ACTIVE_COLS, else 0
o_VSync  out  1  raw VSync: 1 while row < ACTIVE_ROWS, else 0
o_Col_Count  out  10  current column
o_Row_Count  out  10  current row
o_Active  out  1  col < ACTIVE_COLS and row < ACTIVE_ROWS, in RUN/STOP_PEND
o_Frame_Start  out  1  one-cycle pulse at col=0,row=0 of every scanned frame
o_Frame_Count  out  8  completed-frame counter, wraps 255->0
o_Busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE; counters 0; o_Cfg 0; shadow empty; o_Cfg_Ready 1; o_Frame_Count 0; o_Frame_Start 0; o_Busy 0; o_Active 0; o_HSync=o_VSync=1.
- States: IDLE, RUN, STOP_PEND.
  - IDLE -> RUN when i_Start=1. The first RUN cycle shows col=0,row=0 with o_Frame_Start=1.
  - RUN -> STOP_PEND when i_Stop=1 and i_Start=0.
  - STOP_PEND -> RUN when i_Start=1 (cancels the stop).
  - STOP_PEND -> IDLE on the last pixel (col=TOTAL_COLS-1, row=TOTAL_ROWS-1). The next cycle is IDLE with counters 0.
  - In RUN, i_Start and i_Stop both high: i_Start wins, so the sequencer stays in RUN.
- Counters (RUN and STOP_PEND):
  - col increments each clock; at TOTAL_COLS-1 it wraps to 0 and row increments.
  - row wraps to 0 after TOTAL_ROWS-1.
  - In IDLE both are held at 0.
- Sync/active outputs: combinational decode of the registered counters, zero added latency, so they are aligned with o_Col_Count/o_Row_Count. In IDLE: syncs=1, o_Active=0. The downstream porch stage adds 1 cycle to syncs and 2 to video; this block does not compensate.
- o_Frame_Start: registered-equivalent, high exactly on cycles where state is RUN/STOP_PEND and col=0,row=0.
- o_Frame_Count: increments on the last pixel of each frame while scanning. It also increments on the final frame before IDLE. 255 wraps to 0.
- Config handshake:
  - A transfer occurs when i_Cfg_Valid and o_Cfg_Ready are both 1 on a clock edge.
  - In IDLE, the word goes directly to o_Cfg on the next cycle and the shadow stays empty.
  - While scanning, the word goes to the shadow. The shadow becomes full and o_Cfg_Ready drops to 0.
  - On the last pixel of a frame, a full shadow copies to o_Cfg, so the new value is in force at col=0,row=0. The shadow then empties and o_Cfg_Ready returns to 1 on the following cycle.
  - There is no bypass: a word offered on the apply cycle is not accepted.
  - A second valid word while the shadow is full is stalled, not dropped.
  - On the transition STOP_PEND->IDLE, a full shadow is applied like any other frame boundary.
- Reset mid-frame: everything returns immediately to the reset values and the shadow is discarded.

Test Plan:
- Reset then i_Start pulse -> next cycle o_Busy=1, o_Frame_Start=1, col=0,row=0; after 800 clocks row=1, col=0; o_HSync=1 for cols 0-639 and 0 for cols 640-799.
- Run 420000 clocks (one full frame) -> o_Frame_Count=1, a second o_Frame_Start pulse at clock 420000, o_VSync=0 for rows 480-524.
- i_Stop at row 100 -> o_Busy stays 1 until the last pixel of that frame, then IDLE with counters 0, syncs 1 and o_Frame_Count incremented; i_Start during STOP_PEND instead keeps scanning uninterrupted.
- Scanning, config 3'b101 offered at row 10 -> accepted, o_Cfg_Ready=0 for the rest of the frame; o_Cfg changes to 101 exactly at the next col=0,row=0; ready=1 the cycle after.
- Second config 3'b010 held valid while the shadow is full -> not accepted until ready returns, then applied one frame later; in IDLE, config 3'b111 appears on o_Cfg after 1 cycle.
- Assert i_Rst_L=0 asynchronously mid-line with the shadow full -> outputs take reset values without waiting for a clock; after release the previous shadow word never appears on o_Cfg.
